uart_rx_ovs: RTL and testbench

UART_RX_OVS -- requirements
Module: uart_rx_ovs

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_fifo.sv | 83 ++++++++
 rtl/uart_rx_ovs.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_ovs.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
// Vote ticks are derived from the oversample ratio.
package uart_pkg;

    localparam int DEF_OVS    = 16;
    localparam int DEF_DATA_W = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP2,
        S_STOP
    } rx_state_e;

    function automatic int vote_a(input int ovs);
        return ovs / 2 - 1;
    endfunction

    function automatic int vote_b(input int ovs);
        return ovs / 2;
    endfunction

    function automatic int vote_c(input int ovs);
        return ovs / 2 + 1;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer.
// UART_RX_FIFO_EN selects a 2**(CW-1) entry ring; otherwise one holding register.
module uart_rx_fifo #(
    parameter int W  = 9,
    parameter int CW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 2 ** (CW - 1);
    localparam int AW    = CW - 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          wr_en;
    logic          rd_en;

    assign o_full  = (cnt_q == CW'(DEPTH));
    assign o_empty = (cnt_q == '0);
    assign o_count = cnt_q;
    assign o_data  = o_empty ? '0 : mem_q[rd_q];

    // When full, a same-cycle pop frees the slot the push lands in.
    assign wr_en = i_push && (!o_full || i_pop);
    assign rd_en = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wr_q] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) begin
                wr_q <= wr_q + AW'(1);
            end
            if (rd_en) begin
                rd_q <= rd_q + AW'(1);
            end
            cnt_q <= cnt_q + CW'(wr_en) - CW'(rd_en);
        end
    end
`else
    logic [W-1:0] data_q;
    logic         full_q;
    logic         wr_en;

    assign o_full  = full_q;
    assign o_empty = !full_q;
    assign o_count = CW'(full_q);
    assign o_data  = full_q ? data_q : '0;
    assign wr_en   = i_push && (!full_q || i_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (wr_en) begin
            data_q <= i_data;
            full_q <= 1'b1;
        end else if (i_pop) begin
            full_q <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with majority-vote bit decisions and a receive buffer.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry buffer; default is one holding register.
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int OVS        = DEF_OVS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_ce,
    input  logic [1:0]                  i_length,
    input  logic                        i_stop2,
    input  logic                        i_parity,
    input  logic                        i_odd,
    input  logic                        i_rx,
    input  logic                        i_rst_err,
    input  logic                        i_ready,
    output logic [DATA_W-1:0]           o_data,
    output logic                        o_valid,
    output logic                        o_overrun_err,
    output logic                        o_parity_err,
    output logic                        o_frame_err,
    output logic [$clog2(FIFO_DEPTH):0] o_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(DATA_W + 1);

    localparam logic [TW-1:0] T_A   = TW'(vote_a(OVS));
    localparam logic [TW-1:0] T_B   = TW'(vote_b(OVS));
    localparam logic [TW-1:0] T_C   = TW'(vote_c(OVS));
    localparam logic [TW-1:0] T_END = TW'(OVS - 1);

    rx_state_e          state_q;
    logic [1:0]         sync_q;
    logic [TW-1:0]      tick_q;
    logic [1:0]         smp_q;
    logic [BW-1:0]      bits_q;
    logic [BW-1:0]      cnt_q;
    logic [DATA_W-1:0]  shr_q;
    logic [DATA_W-1:0]  word_q;
    logic               par_q;
    logic               paren_q;
    logic               odd_q;
    logic               stop2_q;
    logic               push_q;
    logic               ovr_q;
    logic               perr_q;
    logic               ferr_q;

    logic               rx_s;
    logic               vote;
    logic               vote_t;
    logic               end_t;
    logic               full;
    logic               empty;
    logic               pop;

    assign rx_s   = sync_q[1];
    assign vote   = maj3(smp_q[1], smp_q[0], rx_s);
    assign vote_t = (tick_q == T_C);
    assign end_t  = (tick_q == T_END);
    assign o_valid = !empty;
    assign pop     = o_valid && i_ready;

    assign o_overrun_err = ovr_q;
    assign o_parity_err  = perr_q;
    assign o_frame_err   = ferr_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_rx};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            smp_q   <= '0;
            bits_q  <= '0;
            cnt_q   <= '0;
            shr_q   <= '0;
            word_q  <= '0;
            par_q   <= 1'b0;
            paren_q <= 1'b0;
            odd_q   <= 1'b0;
            stop2_q <= 1'b0;
            push_q  <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            push_q <= 1'b0;
            // Clear first so a same-cycle set below wins.
            if (i_rst_err) begin
                ovr_q  <= 1'b0;
                perr_q <= 1'b0;
                ferr_q <= 1'b0;
            end
            if (push_q && full && !pop) begin
                ovr_q <= 1'b1;
            end
            if (i_ce) begin
                tick_q <= end_t ? '0 : tick_q + TW'(1);
                if (tick_q == T_A || tick_q == T_B) begin
                    smp_q <= {smp_q[0], rx_s};
                end
                unique case (state_q)
                    S_IDLE: begin
                        if (!rx_s) begin
                            state_q <= S_START;
                            tick_q  <= '0;
                            bits_q  <= BW'(DATA_W - 3) + BW'(i_length);
                            paren_q <= i_parity;
                            odd_q   <= i_odd;
                            stop2_q <= i_stop2;
                            cnt_q   <= '0;
                            shr_q   <= '0;
                            par_q   <= 1'b0;
                        end
                    end
                    S_START: begin
                        if (vote_t && vote) begin
                            state_q <= S_IDLE;
                        end else if (end_t) begin
                            state_q <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (vote_t) begin
                            shr_q <= shr_q | (DATA_W'(vote) << cnt_q);
                            cnt_q <= cnt_q + BW'(1);
                            par_q <= par_q ^ vote;
                        end
                        if (end_t && cnt_q == bits_q) begin
                            state_q <= paren_q ? S_PARITY
                                     : stop2_q ? S_STOP2 : S_STOP;
                        end
                    end
                    S_PARITY: begin
                        if (vote_t && (vote != (par_q ^ odd_q))) begin
                            perr_q <= 1'b1;
                        end
                        if (end_t) begin
                            state_q <= stop2_q ? S_STOP2 : S_STOP;
                        end
                    end
                    S_STOP2: begin
                        if (vote_t && !vote) begin
                            ferr_q <= 1'b1;
                        end
                        if (end_t) begin
                            state_q <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        // Leave at mid-bit so the next start edge is caught promptly.
                        if (vote_t) begin
                            if (!vote) begin
                                ferr_q <= 1'b1;
                            end
                            push_q  <= 1'b1;
                            word_q  <= shr_q;
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    uart_rx_fifo #(
        .W  (DATA_W),
        .CW (CW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push_q),
        .i_data  (word_q),
        .i_pop   (pop),
        .o_data  (o_data),
        .o_full  (full),
        .o_empty (empty),
        .o_count (o_count)
    );

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: OVS=16, DATA_W=8, one oversample tick every 4 clocks.
// Expected buffer depth follows UART_RX_FIFO_EN.
module tb_uart_rx_ovs;
    import uart_pkg::*;

    localparam int OVS   = 16;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CEDIV = 4;
    localparam int BITC  = OVS * CEDIV;
`ifdef UART_RX_FIFO_EN
    localparam int EFF = DEPTH;
`else
    localparam int EFF = 1;
`endif

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_ce = 1'b0;
    logic [1:0]    i_length = 2'd3;
    logic          i_stop2 = 1'b0;
    logic          i_parity = 1'b0;
    logic          i_odd = 1'b0;
    logic          i_rx = 1'b1;
    logic          i_rst_err = 1'b0;
    logic          i_ready = 1'b0;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_overrun_err;
    logic          o_parity_err;
    logic          o_frame_err;
    logic [3:0]    o_count;

    int npass = 0;
    int ntot  = 0;
    int vcnt  = 0;
    logic [DW-1:0] vdata = '0;

    uart_rx_ovs #(
        .OVS        (OVS),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_ce          (i_ce),
        .i_length      (i_length),
        .i_stop2       (i_stop2),
        .i_parity      (i_parity),
        .i_odd         (i_odd),
        .i_rx          (i_rx),
        .i_rst_err     (i_rst_err),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_overrun_err (o_overrun_err),
        .o_parity_err  (o_parity_err),
        .o_frame_err   (o_frame_err),
        .o_count       (o_count)
    );

    always #5 clk = ~clk;

    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            c = (c + 1) % CEDIV;
            i_ce = (c == 0);
        end
    end

    always @(negedge clk) begin
        if (o_valid && i_ready) begin
            vcnt  = vcnt + 1;
            vdata = o_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        ntot++;
        if (got === exp) begin
            npass++;
        end else begin
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        i_rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [8:0] d, input int nb, input bit pen,
                        input logic pbit, input int nstop, input bit stop_lo);
        drive(1'b0, BITC);
        for (int i = 0; i < nb; i++) begin
            drive(d[i], BITC);
        end
        if (pen) begin
            drive(pbit, BITC);
        end
        for (int s = 0; s < nstop; s++) begin
            if (stop_lo && s == nstop - 1) begin
                drive(1'b0, 12 * CEDIV);
                drive(1'b1, 4 * CEDIV);
            end else begin
                drive(1'b1, BITC);
            end
        end
        drive(1'b1, 2 * BITC);
    endtask

    task automatic pulse_rst_err();
        i_rst_err = 1'b1;
        @(negedge clk);
        i_rst_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_errs", {29'd0, o_overrun_err, o_parity_err, o_frame_err}, 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(S_IDLE));

        // 8N1 0xA5 with consumer ready
        i_ready = 1'b1;
        vcnt = 0;
        send(9'h0A5, 8, 1'b0, 1'b0, 1, 1'b0);
        chk("a5_data", 32'(vdata), 32'h0A5);
        chk("a5_pulses", vcnt, 32'd1);
        chk("a5_errs", {29'd0, o_overrun_err, o_parity_err, o_frame_err}, 32'd0);
        chk("a5_valid_after", 32'(o_valid), 32'd0);

        // 4-tick glitch
        vcnt = 0;
        drive(1'b0, 4 * CEDIV);
        drive(1'b1, 2 * BITC);
        chk("glitch_pushes", vcnt, 32'd0);
        chk("glitch_count", 32'(o_count), 32'd0);
        chk("glitch_state", 32'(dut.state_q), 32'(S_IDLE));
        chk("glitch_errs", {29'd0, o_overrun_err, o_parity_err, o_frame_err}, 32'd0);

        // 7E2 0x41, even parity would be 0, send 1
        i_length = 2'd2;
        i_parity = 1'b1;
        i_odd    = 1'b0;
        i_stop2  = 1'b1;
        vcnt = 0;
        send(9'h041, 7, 1'b1, 1'b1, 2, 1'b0);
        chk("par_data", 32'(vdata), 32'h41);
        chk("par_pulses", vcnt, 32'd1);
        chk("par_err", 32'(o_parity_err), 32'd1);
        chk("par_ferr", 32'(o_frame_err), 32'd0);
        pulse_rst_err();
        chk("par_cleared", 32'(o_parity_err), 32'd0);

        // 7O1 0x03 with correct odd parity (two ones -> parity bit 1)
        i_odd   = 1'b1;
        i_stop2 = 1'b0;
        vcnt = 0;
        send(9'h003, 7, 1'b1, 1'b1, 1, 1'b0);
        chk("odd_data", 32'(vdata), 32'h03);
        chk("odd_perr", 32'(o_parity_err), 32'd0);

        // Overflow with consumer stalled
        i_length = 2'd3;
        i_parity = 1'b0;
        i_odd    = 1'b0;
        i_ready  = 1'b0;
        for (int k = 1; k <= EFF + 1; k++) begin
            send(9'(k), 8, 1'b0, 1'b0, 1, 1'b0);
        end
        chk("ovf_count", 32'(o_count), 32'(EFF));
        chk("ovf_err", 32'(o_overrun_err), 32'd1);
        chk("ovf_valid", 32'(o_valid), 32'd1);
        for (int k = 1; k <= EFF; k++) begin
            chk("ovf_pop", 32'(o_data), 32'(k));
            i_ready = 1'b1;
            @(negedge clk);
            i_ready = 1'b0;
            @(negedge clk);
        end
        chk("ovf_drained", 32'(o_count), 32'd0);
        chk("ovf_valid_end", 32'(o_valid), 32'd0);
        pulse_rst_err();
        chk("ovf_cleared", 32'(o_overrun_err), 32'd0);

        // Stop bit low on 0x3C, held in the buffer
        send(9'h03C, 8, 1'b0, 1'b0, 1, 1'b1);
        chk("ferr_data", 32'(o_data), 32'h3C);
        chk("ferr_valid", 32'(o_valid), 32'd1);
        chk("ferr_count", 32'(o_count), 32'd1);
        chk("ferr_err", 32'(o_frame_err), 32'd1);
        chk("ferr_perr", 32'(o_parity_err), 32'd0);

        // Reset in the middle of a frame
        drive(1'b0, BITC);
        drive(1'b0, BITC);
        drive(1'b1, BITC / 2);
        i_rst = 1'b1;
        i_rx  = 1'b1;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        chk("mrst_state", 32'(dut.state_q), 32'(S_IDLE));
        chk("mrst_valid", 32'(o_valid), 32'd0);
        chk("mrst_data", 32'(o_data), 32'd0);
        chk("mrst_count", 32'(o_count), 32'd0);
        chk("mrst_errs", {29'd0, o_overrun_err, o_parity_err, o_frame_err}, 32'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
